// File: rtl/player_controller_if.sv
// Team position bus: game state and raw buttons into a player_controller, player positions out.
interface player_controller_if;
    logic       game_on;
    logic       game_over;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [9:0] ver_pos;
    logic [9:0] hor_pos;
    logic       pos_update;

    modport master (
        output game_on, game_over, btn_up, btn_down, btn_left, btn_right,
        input  ver_pos, hor_pos, pos_update
    );

    modport slave (
        input  game_on, game_over, btn_up, btn_down, btn_left, btn_right,
        output ver_pos, hor_pos, pos_update
    );
endinterface

// File: rtl/player_controller.sv
// One team's vertical/horizontal rod player: debounced buttons step the players per movement tick, clamped to the pitch.
// Optional build macro PLAYER_ACCEL_EN doubles the step after ACCEL_HOLD ticks of continuous same-direction hold.
module player_controller #(
    parameter int PLAYER_RADIUS      = 35,
    parameter int MOVEMENT_FREQUENCY = 200000,
    parameter int DEBOUNCE_CYCLES    = 250000,
    parameter int VER_HOME           = 275,
    parameter int HOR_HOME           = 405,
    parameter int ACCEL_HOLD         = 64
) (
    input logic                clk,
    input logic                rst,
    player_controller_if.slave bus
);
    localparam int VER_MIN = 36 + PLAYER_RADIUS;
    localparam int VER_MAX = 510 - PLAYER_RADIUS;
    localparam int HOR_MIN = 150 + PLAYER_RADIUS;
    localparam int HOR_MAX = 660 - PLAYER_RADIUS;
    localparam int TICK_W  = $clog2(MOVEMENT_FREQUENCY + 2);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    // Button bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right.
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    state_t                state_q, state_d;
    logic [9:0]            ver_q, ver_d;
    logic [9:0]            hor_q, hor_d;
    logic                  upd_q, upd_d;
    logic                  tick;
    logic [1:0]            vdir, hdir;
    logic [1:0]            vstep, hstep;

    function automatic logic signed [10:0] step_pos(input logic [9:0] pos,
                                                    input logic [1:0] dir,
                                                    input logic [1:0] step);
        logic signed [10:0] base;
        logic signed [10:0] delta;
        base  = $signed({1'b0, pos});
        delta = $signed({9'd0, step});
        case (dir)
            2'b01:   return base - delta;
            2'b10:   return base + delta;
            default: return base;
        endcase
    endfunction

    function automatic logic [9:0] clamp_pos(input logic signed [10:0] val,
                                             input int lo, input int hi);
        if (val < lo) return 10'(lo);
        if (val > hi) return 10'(hi);
        return val[9:0];
    endfunction

    // Direction code {plus, minus}; opposing buttons cancel to 2'b00.
    assign vdir = {deb_q[1] & ~deb_q[0], deb_q[0] & ~deb_q[1]};
    assign hdir = {deb_q[3] & ~deb_q[2], deb_q[2] & ~deb_q[3]};
    assign tick = (tick_cnt_q == TICK_W'(MOVEMENT_FREQUENCY));

`ifdef PLAYER_ACCEL_EN
    localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);

    logic [1:0]        vdir_q, vdir_d, hdir_q, hdir_d;
    logic [HOLD_W-1:0] vhold_q, vhold_d, hhold_q, hhold_d;

    function automatic logic [HOLD_W-1:0] next_hold(input logic [1:0] dir,
                                                    input logic [1:0] prev,
                                                    input logic [HOLD_W-1:0] hold);
        if (dir == 2'b00) return '0;
        if (dir != prev) return HOLD_W'(1);
        if (hold == HOLD_W'(ACCEL_HOLD)) return hold;
        return hold + HOLD_W'(1);
    endfunction

    // The doubled step uses the hold count reached before this tick.
    assign vstep = (vdir != 2'b00 && vdir == vdir_q && vhold_q == HOLD_W'(ACCEL_HOLD)) ? 2'd2 : 2'd1;
    assign hstep = (hdir != 2'b00 && hdir == hdir_q && hhold_q == HOLD_W'(ACCEL_HOLD)) ? 2'd2 : 2'd1;

    always_comb begin
        vdir_d  = vdir_q;
        hdir_d  = hdir_q;
        vhold_d = vhold_q;
        hhold_d = hhold_q;
        if (state_q != PLAY) begin
            vdir_d  = 2'b00;
            hdir_d  = 2'b00;
            vhold_d = '0;
            hhold_d = '0;
        end else if (tick) begin
            vdir_d  = vdir;
            hdir_d  = hdir;
            vhold_d = next_hold(vdir, vdir_q, vhold_q);
            hhold_d = next_hold(hdir, hdir_q, hhold_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdir_q  <= 2'b00;
            hdir_q  <= 2'b00;
            vhold_q <= '0;
            hhold_q <= '0;
        end else begin
            vdir_q  <= vdir_d;
            hdir_q  <= hdir_d;
            vhold_q <= vhold_d;
            hhold_q <= hhold_d;
        end
    end
`else
    // ACCEL_HOLD only shapes the accelerated build; here every move is one pixel.
    assign vstep = (ACCEL_HOLD > 0) ? 2'd1 : 2'd1;
    assign hstep = 2'd1;
`endif

    always_comb begin
        sync1_d    = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = deb_cnt_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

        // A level is accepted on its DEBOUNCE_CYCLES-th consecutive differing cycle.
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.game_on && !bus.game_over) state_d = PLAY;
            PLAY:    if (bus.game_over) state_d = OVER;
            OVER:    if (!bus.game_on && !bus.game_over) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ver_d = ver_q;
        hor_d = hor_q;
        if (state_q == IDLE) begin
            ver_d = 10'(VER_HOME);
            hor_d = 10'(HOR_HOME);
        end else if (state_q == PLAY && tick) begin
            ver_d = clamp_pos(step_pos(ver_q, vdir, vstep), VER_MIN, VER_MAX);
            hor_d = clamp_pos(step_pos(hor_q, hdir, hstep), HOR_MIN, HOR_MAX);
        end

        // Strobe only on a visible change, so a saturated clamp stays silent.
        upd_d = (ver_d != ver_q) || (hor_d != hor_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_cnt_q  <= '0;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            ver_q      <= 10'(VER_HOME);
            hor_q      <= 10'(HOR_HOME);
            upd_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            ver_q      <= ver_d;
            hor_q      <= hor_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.ver_pos    = ver_q;
    assign bus.hor_pos    = hor_q;
    assign bus.pos_update = upd_q;
endmodule

// File: tb/tb_player_controller.sv
// Self-checking bench for player_controller: table of button holds plus hand sequences, scoreboarded per pos_update.
module tb_player_controller;
    localparam int MF = 4;
    localparam int DB = 3;
    localparam int AH = 2;
    localparam int NV = 8;

    typedef struct {
        int v;
        int h;
    } pos_t;

    typedef struct {
        logic [3:0] btn;
        int         ticks;
        int         ev;
        int         eh;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   upd_count = 0;
    int   mv, mh;
    int   u0;
    pos_t exp_q[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;

    player_controller_if bus();

    player_controller #(
        .PLAYER_RADIUS(35),
        .MOVEMENT_FREQUENCY(MF),
        .DEBOUNCE_CYCLES(DB),
        .VER_HOME(275),
        .HOR_HOME(405),
        .ACCEL_HOLD(AH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic sample();
        pos_t e;
        if (bus.pos_update === 1'b1) begin
            upd_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_update ver=%0d hor=%0d required=no update",
                         bus.ver_pos, bus.hor_pos);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.ver_pos) != e.v || int'(bus.hor_pos) != e.h) begin
                    failures++;
                    $display("FAIL update_value ver=%0d hor=%0d required ver=%0d hor=%0d",
                             bus.ver_pos, bus.hor_pos, e.v, e.h);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample();
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        bus.btn_up    = b[0];
        bus.btn_down  = b[1];
        bus.btn_left  = b[2];
        bus.btn_right = b[3];
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Expected positions for n ticks of a steady hold, starting from a released state.
    task automatic push_moves(input logic [3:0] b, input int n);
        int   dv, dh, sv, nv, nh;
        pos_t p;
        dv = (b[1] && !b[0]) ? 1 : (b[0] && !b[1]) ? -1 : 0;
        dh = (b[3] && !b[2]) ? 1 : (b[2] && !b[3]) ? -1 : 0;
        for (int k = 0; k < n; k++) begin
`ifdef PLAYER_ACCEL_EN
            sv = (k >= AH) ? 2 : 1;
`else
            sv = 1;
`endif
            nv = clampi(mv + dv * sv, 71, 475);
            nh = clampi(mh + dh * sv, 185, 625);
            if (nv != mv || nh != mh) begin
                p.v = nv;
                p.h = nh;
                exp_q.push_back(p);
            end
            mv = nv;
            mh = nh;
        end
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        pos_t p;
        vecs[0] = '{4'b0001, 1,   274, 405};
        vecs[1] = '{4'b0010, 4,   278, 405};
        vecs[2] = '{4'b0100, 222, 278, 185};
        vecs[3] = '{4'b0001, 210, 71,  185};
        vecs[4] = '{4'b0011, 10,  71,  185};
        vecs[5] = '{4'b1000, 3,   71,  188};
        vecs[6] = '{4'b0010, 229, 300, 188};
        vecs[7] = '{4'b1100, 2,   300, 188};

        bus.game_on   = 1'b0;
        bus.game_over = 1'b0;
        set_btn(4'b0000);

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_ver", bus.ver_pos, 275);
        check("reset_hor", bus.hor_pos, 405);
        check("reset_upd", bus.pos_update, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mv = 275;
        mh = 405;

        bus.game_on = 1'b1;
        cyc(3);

        // Two-cycle glitches never survive a three-cycle debounce.
        for (int r = 0; r < 6; r++) begin
            bus.btn_up = 1'b1;
            cyc(2);
            bus.btn_up = 1'b0;
            cyc(2);
        end
        cyc(8);
        check("bounce_ver", bus.ver_pos, 275);
        check("bounce_updates", upd_count, 0);

        // A hold of 5*n cycles spans exactly n movement ticks whatever the tick phase.
        for (int i = 0; i < NV; i++) begin
            push_moves(vecs[i].btn, vecs[i].ticks);
            set_btn(vecs[i].btn);
            cyc(5 * vecs[i].ticks);
            set_btn(4'b0000);
            cyc(8);
            check_drained($sformatf("vec%0d_drained", i));
`ifdef PLAYER_ACCEL_EN
            check($sformatf("vec%0d_ver", i), bus.ver_pos, mv);
            check($sformatf("vec%0d_hor", i), bus.hor_pos, mh);
            if (i == 1) check("accel_1122_ver", bus.ver_pos, 280);
`else
            check($sformatf("vec%0d_ver", i), bus.ver_pos, vecs[i].ev);
            check($sformatf("vec%0d_hor", i), bus.hor_pos, vecs[i].eh);
`endif
        end

        // game_over freezes the players even with a button held.
        bus.game_over = 1'b1;
        cyc(2);
        u0 = upd_count;
        bus.btn_down = 1'b1;
        cyc(20);
        bus.btn_down = 1'b0;
        cyc(8);
        check("over_frozen_updates", upd_count - u0, 0);
        check("over_frozen_ver", bus.ver_pos, mv);

        // Leaving OVER returns to IDLE and homes both players with a single strobe.
        p.v = 275;
        p.h = 405;
        exp_q.push_back(p);
        mv = 275;
        mh = 405;
        u0 = upd_count;
        bus.game_on   = 1'b0;
        bus.game_over = 1'b0;
        cyc(6);
        check("home_pulses", upd_count - u0, 1);
        check("home_ver", bus.ver_pos, 275);
        check("home_hor", bus.hor_pos, 405);
        check_drained("home_drained");

        // IDLE ignores buttons.
        bus.btn_down = 1'b1;
        cyc(15);
        bus.btn_down = 1'b0;
        cyc(8);
        check("idle_ver", bus.ver_pos, 275);

        // Move away from home, then assert reset between clock edges.
        bus.game_on = 1'b1;
        cyc(3);
        push_moves(4'b0010, 2);
        set_btn(4'b0010);
        cyc(10);
        set_btn(4'b0000);
        cyc(8);
        check_drained("pre_reset_drained");
        check("pre_reset_ver", bus.ver_pos, 277);
        set_btn(4'b0010);
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_ver", bus.ver_pos, 275);
        check("midrun_reset_hor", bus.hor_pos, 405);
        check("midrun_reset_upd", bus.pos_update, 0);
        bus.game_on = 1'b0;
        set_btn(4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc(10);
        check("post_reset_idle_ver", bus.ver_pos, 275);
        check_drained("final_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
